// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter.
// Data length, parity, stop bits and baud divisor are latched per frame.
module uart_tx_cfg #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [1:0]        cfg_parity,
  input  logic              cfg_stop2,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  state_t             state_q, state_n;
  logic [DIV_W-1:0]   cnt_q, cnt_n;
  logic [LEN_W-1:0]   idx_q, idx_n;
  logic [DATA_W-1:0]  sh_q, sh_n;
  logic [DIV_W-1:0]   div_q;
  logic [LEN_W-1:0]   len_q;
  logic               par_en_q, par_bit_q;
  logic               stop2_q;
  logic               tx_q, tx_n;
  logic               done_q, done_n;

  logic [DIV_W-1:0]   div_eff;
  logic [LEN_W-1:0]   len_eff;
  logic               par_calc;
  logic               cnt_last;
  logic               stop_last;
  logic               xfer;

  // Sanitise the incoming config and precompute the frame's parity bit.
  always_comb begin
    div_eff  = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;
    len_eff  = cfg_len;
    if (cfg_len == '0 || cfg_len > LEN_W'(DATA_W))
      len_eff = LEN_W'(DATA_W);
    par_calc = cfg_parity[1];
    for (int i = 0; i < DATA_W; i++)
      if (LEN_W'(i) < len_eff)
        par_calc = par_calc ^ s_data[i];
  end

  assign cnt_last  = (cnt_q == div_q - DIV_W'(1));
  assign stop_last = (idx_q == LEN_W'(stop2_q));
  assign s_ready   = (state_q == IDLE) ||
                     (state_q == STOP && cnt_last && stop_last);
  assign xfer      = s_valid && s_ready;
  assign tx        = tx_q;
  assign busy      = (state_q != IDLE);
  assign tx_done   = done_q;

  // Next-state, bit counter, shifter and next line level.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q + DIV_W'(1);
    idx_n   = idx_q;
    sh_n    = sh_q;
    tx_n    = tx_q;
    done_n  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_n = '0;
        tx_n  = 1'b1;
      end
      START: begin
        tx_n = 1'b0;
        if (cnt_last) begin
          state_n = DATA;
          cnt_n   = '0;
          idx_n   = '0;
          tx_n    = sh_q[0];
        end
      end
      DATA: begin
        if (cnt_last) begin
          cnt_n = '0;
          if (idx_q == len_q - LEN_W'(1)) begin
            idx_n = '0;
            if (par_en_q) begin
              state_n = PARITY;
              tx_n    = par_bit_q;
            end else begin
              state_n = STOP;
              tx_n    = 1'b1;
            end
          end else begin
            idx_n = idx_q + LEN_W'(1);
            sh_n  = sh_q >> 1;
            tx_n  = sh_n[0];
          end
        end
      end
      PARITY: begin
        if (cnt_last) begin
          state_n = STOP;
          cnt_n   = '0;
          idx_n   = '0;
          tx_n    = 1'b1;
        end
      end
      STOP: begin
        tx_n = 1'b1;
        if (cnt_last) begin
          cnt_n = '0;
          if (stop_last) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            idx_n = idx_q + LEN_W'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
    if (xfer) begin
      state_n = START;
      cnt_n   = '0;
      idx_n   = '0;
      sh_n    = s_data;
      tx_n    = 1'b0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      sh_q    <= sh_n;
      tx_q    <= tx_n;
      done_q  <= done_n;
    end
  end

  // Frame configuration, captured only on a transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q     <= DIV_W'(2);
      len_q     <= LEN_W'(DATA_W);
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
    end else if (xfer) begin
      div_q     <= div_eff;
      len_q     <= len_eff;
      par_en_q  <= ^cfg_parity;
      par_bit_q <= par_calc;
      stop2_q   <= cfg_stop2;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: per-cycle line model plus
// directed frames with literal bit patterns.
module tb_uart_tx_cfg;

  localparam int DATA_W = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cfg_div;
  logic [3:0]  cfg_len;
  logic [1:0]  cfg_parity;
  logic        cfg_stop2;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        tx;
  logic        busy;
  logic        tx_done;

  int errors = 0;
  int checks = 0;

  uart_tx_cfg dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_div    (cfg_div),
    .cfg_len    (cfg_len),
    .cfg_parity (cfg_parity),
    .cfg_stop2  (cfg_stop2),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: queue of line levels still to be driven, one per cycle,
  // with a flag marking the last cycle of each frame.
  bit mq[$];
  bit ml[$];
  bit fb[$];
  bit mdone;
  bit mrdy;
  bit mp;
  int de, le;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      ml.delete();
      mdone = 1'b0;
    end else begin
      mrdy  = (mq.size() <= 1);
      mdone = 1'b0;
      if (mq.size() > 0) begin
        mdone = ml.pop_front();
        void'(mq.pop_front());
      end
      if (s_valid && mrdy) begin
        de = (cfg_div < 2) ? 2 : int'(cfg_div);
        le = (cfg_len == 0 || cfg_len > DATA_W) ? DATA_W : int'(cfg_len);
        fb.delete();
        fb.push_back(1'b0);
        mp = 1'b0;
        for (int i = 0; i < le; i++) begin
          fb.push_back(s_data[i]);
          mp ^= s_data[i];
        end
        if (cfg_parity == 2'b01) fb.push_back(mp);
        if (cfg_parity == 2'b10) fb.push_back(!mp);
        fb.push_back(1'b1);
        if (cfg_stop2) fb.push_back(1'b1);
        foreach (fb[b])
          for (int c = 0; c < de; c++) begin
            mq.push_back(fb[b]);
            ml.push_back(b == fb.size() - 1 && c == de - 1);
          end
      end
    end
    #2;
    chk("m_tx", 32'(tx), 32'((mq.size() > 0) ? mq[0] : 1'b1));
    chk("m_busy", 32'(busy), 32'(mq.size() > 0));
    chk("m_ready", 32'(s_ready), 32'(mq.size() <= 1));
    chk("m_done", 32'(tx_done), 32'(mdone));
  end

  logic cap [400];

  // One frame from idle; pat lists the line bits in send order, MSB first.
  task automatic send(input string nm, input logic [15:0] dv,
                      input logic [3:0] ln, input logic [1:0] pm,
                      input logic st, input logic [7:0] d,
                      input logic [15:0] pat, input int nb,
                      input int flen);
    int dd, k, nbusy;
    bit got;
    dd = (dv < 2) ? 2 : int'(dv);
    @(negedge clk);
    cfg_div = dv; cfg_len = ln; cfg_parity = pm;
    cfg_stop2 = st; s_data = d; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    chk({nm, "_mlen"}, 32'(mq.size()), 32'(flen));
    k = 0; nbusy = 0; got = 1'b0;
    while (!got && k < 400) begin
      if (tx_done) got = 1'b1;
      else begin
        cap[k] = tx;
        if (busy) nbusy++;
        if (k == 3) begin
          cfg_len = 4'd1; cfg_div = 16'd5;
          cfg_parity = 2'b11; cfg_stop2 = ~st;
        end
        k++;
        @(negedge clk);
      end
    end
    chk({nm, "_len"}, 32'(k), 32'(flen));
    chk({nm, "_busy"}, 32'(nbusy), 32'(flen));
    for (int b = 0; b < nb; b++)
      chk({nm, "_bit"}, 32'(cap[b * dd + dd / 2]), 32'(pat[nb - 1 - b]));
  endtask

  logic [7:0] w [3];
  int nx, nd, gap, wi;
  bit pend;

  initial begin
    reset = 1'b1; s_valid = 1'b0; s_data = '0;
    cfg_div = 16'd4; cfg_len = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    #1;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_ready", 32'(s_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(tx_done), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    send("f8n1", 16'd4, 4'd8, 2'b00, 1'b0, 8'hAB, 16'b0110101011, 10, 40);
    send("f7e1", 16'd3, 4'd7, 2'b01, 1'b0, 8'h55, 16'b0101010101, 10, 30);
    send("f7o1", 16'd3, 4'd7, 2'b10, 1'b0, 8'h55, 16'b0101010111, 10, 30);
    send("f5o2", 16'd2, 4'd5, 2'b10, 1'b1, 8'hFF, 16'b011111011, 9, 18);
    send("div0", 16'd0, 4'd8, 2'b00, 1'b0, 8'hA5, 16'b0101001011, 10, 20);
    send("div1", 16'd1, 4'd0, 2'b11, 1'b0, 8'h3C, 16'b0001111001, 10, 20);

    // Back-to-back words with s_valid held high.
    w[0] = 8'h01; w[1] = 8'h80; w[2] = 8'hF0;
    @(negedge clk);
    cfg_div = 16'd4; cfg_len = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    nx = 0; nd = 0; gap = 0; wi = 0; pend = 1'b0;
    s_data = w[0]; s_valid = 1'b1;
    for (int c = 0; c < 200 && nd < 3; c++) begin
      if (pend) begin
        nx++; wi++;
        if (wi < 3) s_data = w[wi];
        else s_valid = 1'b0;
      end
      if (tx_done) nd++;
      if (nx >= 1 && nd < 3 && !busy) gap++;
      pend = s_valid && s_ready;
      @(negedge clk);
    end
    s_valid = 1'b0;
    chk("b2b_xfers", 32'(nx), 32'd3);
    chk("b2b_dones", 32'(nd), 32'd3);
    chk("b2b_gap", 32'(gap), 32'd0);

    // Reset in the middle of data bit 3 of a div=8 frame.
    @(negedge clk);
    cfg_div = 16'd8; cfg_len = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    s_data = 8'h00; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    repeat (35) @(negedge clk);
    chk("mid_tx_low", 32'(tx), 32'd0);
    reset = 1'b1;
    #1;
    chk("mid_rst_tx", 32'(tx), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    nd = 0;
    repeat (4) begin
      @(negedge clk);
      if (tx_done) nd++;
    end
    chk("post_rst_done", 32'(nd), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    send("after", 16'd8, 4'd8, 2'b00, 1'b0, 8'hC3, 16'b0110000111, 10, 80);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Runtime-configurable UART transmitter that serialises one word per valid/ready handshake onto a single idle-high line. It generalises the fixed 8N1 transmitter with these runtime settings: data length, parity mode, one or two stop bits, and a runtime baud divisor. Configuration is latched per frame. It sits between a host/CSR-fed byte source and the pad driver.

Parameters:
DATA_W, 8, maximum data bits per frame (≥5)
DIV_W, 16, width of baud divisor input
LEN_W, 4, width of cfg_len (must hold DATA_W)

Ports:
clk  input  1  system clock
reset  input  1  reset, asynchronous, active-high
cfg_div  input  DIV_W  clock cycles per bit; values 0 and 1 are treated as 2
cfg_len  input  LEN_W  data bits per frame; valid range 1..DATA_W; 0 or >DATA_W treated as DATA_W
cfg_parity  input  2  00 none, 01 even, 10 odd, 11 none
cfg_stop2  input  1  0: one stop bit, 1: two stop bits
s_valid  input  1  word available
s_data  input  DATA_W  word to send, LSB first
s_ready  output  1  transmitter can accept a word this cycle
tx  output  1  serial line, idle high
busy  output  1  frame in progress
tx_done  output  1  single-cycle pulse at end of frame

Behaviour:
- Reset (async): tx=1, s_ready=1, busy=0, tx_done=0, state IDLE, all counters 0. Reset asserted mid-frame forces tx=1 immediately and abandons the frame. No partial frame resumes after reset.
- States: IDLE, START, DATA, PARITY, STOP.
- Handshake: a transfer occurs on a clk edge where s_valid && s_ready. s_ready is combinational: it is high in IDLE, and also high in the final cycle of the last stop bit. On transfer, the block latches s_data, the effective divisor, length, parity and stop settings. Config changes during a frame have no effect until the next transfer.
- Latency: tx drives the start bit (0) in the cycle after the transfer edge; the outputs are registered.
- Bit timing: every bit, including start, data, parity and each stop bit, lasts exactly div_eff cycles, counted by a bit-cycle counter running 0..div_eff-1.
- Bit order:
  - START: 0.
  - DATA: s_data[0]..s_data[len-1]. Bits at or above len are ignored.
  - PARITY (only if mode is even or odd): even = XOR of the transmitted data bits; odd = inverted XOR.
  - STOP: 1, for 1 or 2 bit periods.
- Transitions:
  - IDLE→START on transfer.
  - START→DATA after one period.
  - DATA→PARITY or DATA→STOP after len periods.
  - PARITY→STOP after one period.
  - STOP→IDLE after the configured number of stop periods.
  - STOP→START directly if a transfer occurs in the final stop cycle. This gives back-to-back frames with zero idle gap.
- tx_done: high for exactly one cycle, in the first cycle after the final stop period completes. That is the cycle where tx shows idle 1 or the next start bit 0.
- busy is high from the cycle after transfer through the last stop cycle.
- Frame length = (1 + len + p + s) × div_eff cycles, where p∈{0,1} and s∈{1,2}.
- Counters never wrap mid-bit. The maximum div_eff is 2^DIV_W−1. cfg_div = all-ones is legal.
- s_valid held with s_ready low: data is neither lost nor duplicated. The source must hold s_data stable until transfer.

Test Plan:
- div=4, len=8, parity none, 1 stop, s_data=0xAB, one-cycle valid → tx = 0,1,1,0,1,0,1,0,1,1, each bit 4 cycles. Start appears 1 cycle after transfer. tx_done pulses 40 cycles after the start bit begins. busy=1 for 40 cycles.
- div=3, len=7, even parity, s_data=0x55 → data 1,0,1,0,1,0,1, parity 0, then 1 stop; 30-cycle frame. Repeat with odd parity → parity bit 1.
- div=2, len=5, odd parity, 2 stops, s_data=0xFF → tx = 0,1,1,1,1,1,0,1,1; 18-cycle frame; upper 3 data bits not sent.
- s_valid held high with 3 words (0x01, 0x80, 0xF0), div=4, 8N1 → three contiguous 40-cycle frames with no idle cycle between stop and next start. Exactly 3 transfers and 3 tx_done pulses.
- cfg_div=0, then 1 → each bit lasts 2 cycles. Change cfg_len mid-frame → current frame is unaffected.
- Assert reset during data bit 3 of a div=8 frame → tx=1 in the same cycle. After release: s_ready=1, busy=0, no tx_done pulse, and the next transfer sends a clean full frame.
